// File: rtl/fp_pkg.sv
// Shared types and field constants for the FP datapath.
package fp_pkg;

  localparam int MANT_W  = 26;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  localparam int HIDDEN  = 25;
  localparam int GUARD   = 1;
  localparam int STICKY  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fp_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even decision and increment on a 27-bit carry:mantissa word.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W:0] mant_i,
  output logic            round_up_o,
  output logic [MANT_W:0] mant_o
);

  // Ties go up only when the LSB of the kept fraction (bit 2) is odd.
  assign round_up_o = mant_i[GUARD] & (mant_i[STICKY] | mant_i[GUARD+1]);

  always_comb begin
    mant_o = mant_i;
    if (round_up_o) begin
      mant_o = mant_i + (MANT_W+1)'(4);
      mant_o[GUARD:STICKY] = 2'b00;
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Iterative post-add normalizer: one shift per cycle, then RNE rounding.
//   state | meaning
//   IDLE  | waiting for start, result outputs held
//   NORM  | one right/left normalization shift per cycle
//   ROUND | round to nearest even, classify exponent
//   DONE  | done pulse, result valid
module fp_normalizer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mantissa_in,
  input  logic              carry_in,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic              sign_in,
  output logic              busy,
  output logic              done,
  output logic [FRAC_W-1:0] mantissa_out,
  output logic [EXP_W-1:0]  exponent_out,
  output logic              sign_out,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  fp_state_e         state_q, state_d;
  logic [MANT_W:0]   mant_q, mant_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;

  logic [MANT_W:0]   mant_rnd;
  logic              round_up;

  fp_round_rne u_round (
    .mant_i     (mant_q),
    .round_up_o (round_up),
    .mant_o     (mant_rnd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mant_q    <= '0;
      exp_q     <= '0;
      frac_q    <= '0;
      exp_out_q <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mant_q    <= mant_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      exp_out_q <= exp_out_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mant_d    = mant_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    exp_out_d = exp_out_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mant_d    = {carry_in, mantissa_in};
          // A zero biased exponent is the denormal scale, i.e. 2^(1-BIAS).
          exp_d     = (exponent_in == '0) ? (EXP_W+1)'(1) : {1'b0, exponent_in};
          sign_d    = sign_in;
          frac_d    = '0;
          exp_out_d = '0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          zero_d    = 1'b0;
          state_d   = NORM;
        end
      end
      NORM: begin
        if (mant_q[MANT_W]) begin
          mant_d = {1'b0, mant_q[MANT_W:2], mant_q[GUARD] | mant_q[STICKY]};
          exp_d  = exp_q + (EXP_W+1)'(1);
        end else if (mant_q == '0) begin
          exp_d     = '0;
          exp_out_d = '0;
          zero_d    = 1'b1;
          state_d   = DONE;
        end else if (!mant_q[HIDDEN] && (exp_q > (EXP_W+1)'(1))) begin
          mant_d = {mant_q[MANT_W-1:0], 1'b0};
          exp_d  = exp_q - (EXP_W+1)'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        mant_d = mant_rnd;
        if (mant_rnd[MANT_W]) begin
          state_d = NORM;
        end else begin
          state_d = DONE;
          if (exp_q >= (EXP_W+1)'(EXP_MAX)) begin
            ovf_d     = 1'b1;
            exp_out_d = EXP_W'(EXP_MAX);
            frac_d    = '0;
          end else if (!mant_rnd[HIDDEN]) begin
            unf_d     = 1'b1;
            exp_out_d = '0;
            frac_d    = mant_rnd[HIDDEN-1:2];
          end else begin
            exp_out_d = exp_q[EXP_W-1:0];
            frac_d    = mant_rnd[HIDDEN-1:2];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mantissa_out = frac_q;
  assign exponent_out = exp_out_q;
  assign sign_out     = sign_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench: directed cases with fixed expectations plus random ops vs an arithmetic model.
module tb_fp_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [25:0] mantissa_in;
  logic        carry_in;
  logic [7:0]  exponent_in;
  logic        sign_in;
  logic        busy;
  logic        done;
  logic [22:0] mantissa_out;
  logic [7:0]  exponent_out;
  logic        sign_out;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int frac;
    int expo;
    int ovf;
    int unf;
    int zro;
    int lat;
  } res_t;

  fp_normalizer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mantissa_in  (mantissa_in),
    .carry_in     (carry_in),
    .exponent_in  (exponent_in),
    .sign_in      (sign_in),
    .busy         (busy),
    .done         (done),
    .mantissa_out (mantissa_out),
    .exponent_out (exponent_out),
    .sign_out     (sign_out),
    .overflow     (overflow),
    .underflow    (underflow),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic res_t mk(int frac, int expo, int ovf, int unf, int zro, int lat);
    res_t r;
    r.frac = frac; r.expo = expo; r.ovf = ovf; r.unf = unf; r.zro = zro; r.lat = lat;
    return r;
  endfunction

  // Value = m * 2^(e - BIAS - 25) with m holding 2 extra low bits; normalize by doubling/halving.
  function automatic res_t model(bit c, bit [25:0] mi, bit [7:0] ei);
    localparam longint ONE = 64'd1 << 25;
    localparam longint TWO = 64'd1 << 26;
    res_t   r;
    longint m;
    int     e;
    longint g, s, l, st;
    r = mk(0, 0, 0, 0, 0, 0);
    m = longint'(mi) + (c ? TWO : 64'd0);
    e = (ei == 8'd0) ? 1 : int'(ei);
    if (m == 0) begin
      r.zro = 1;
      r.lat = 1;
      return r;
    end
    for (int pass = 0; pass < 3; pass++) begin
      while (m >= TWO) begin
        st = ((m % 4) != 0) ? 1 : 0;
        m  = (m / 4) * 2 + st;
        e++;
        r.lat++;
      end
      while (m < ONE && e > 1) begin
        m = m * 2;
        e--;
        r.lat++;
      end
      r.lat += 2;
      g = (m / 2) % 2;
      s = m % 2;
      l = (m / 4) % 2;
      if (g == 1 && (s == 1 || l == 1)) m = (m / 4 + 1) * 4;
      if (m < TWO) break;
    end
    if (e >= 255) begin
      r.ovf  = 1;
      r.expo = 255;
    end else if (m < ONE) begin
      r.unf  = 1;
      r.frac = int'((m / 4) % (64'd1 << 23));
    end else begin
      r.expo = e;
      r.frac = int'((m / 4) % (64'd1 << 23));
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input bit c, input bit [25:0] mi, input bit [7:0] ei,
                        input bit sg, input bit glitch, input res_t w);
    int edges;
    logic [22:0] f_hold;
    @(negedge clk);
    carry_in    = c;
    mantissa_in = mi;
    exponent_in = ei;
    sign_in     = sg;
    start       = 1'b1;
    @(negedge clk);
    edges = 0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".clr"}, {overflow, underflow, zero, exponent_out, mantissa_out}, 0);
    if (glitch) begin
      carry_in    = ~c;
      mantissa_in = ~mi;
      exponent_in = ~ei;
      sign_in     = ~sg;
    end else begin
      start = 1'b0;
    end
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
      start = 1'b0;
    end
    if (!done) chk({tag, ".timeout"}, 0, 1);
    chk({tag, ".lat"},  edges,        w.lat);
    chk({tag, ".frac"}, mantissa_out, w.frac);
    chk({tag, ".exp"},  exponent_out, w.expo);
    chk({tag, ".sign"}, sign_out,     sg);
    chk({tag, ".ovf"},  overflow,     w.ovf);
    chk({tag, ".unf"},  underflow,    w.unf);
    chk({tag, ".zero"}, zero,         w.zro);
    f_hold = mantissa_out;
    @(negedge clk);
    chk({tag, ".pulse"}, {busy, done}, 0);
    @(negedge clk);
    chk({tag, ".hold"}, {overflow, underflow, zero, exponent_out, mantissa_out},
        {w.ovf[0], w.unf[0], w.zro[0], 8'(w.expo), 23'(w.frac)});
    chk({tag, ".holdf"}, mantissa_out, f_hold);
  endtask

  initial begin
    bit [25:0] rm;
    bit [7:0]  re;
    bit        rc;
    int        sel;
    bit        saw_done;

    rst         = 1'b1;
    start       = 1'b0;
    mantissa_in = '0;
    carry_in    = 1'b0;
    exponent_in = '0;
    sign_in     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {busy, done, sign_out, overflow, underflow, zero, exponent_out, mantissa_out}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_op("norm",    1'b0, 26'h2000000, 8'd127, 1'b0, 1'b0, mk(0, 127, 0, 0, 0, 2));
    run_op("carry",   1'b1, 26'h0000000, 8'd127, 1'b1, 1'b0, mk(0, 128, 0, 0, 0, 3));
    run_op("lshift",  1'b0, 26'h0800000, 8'd127, 1'b0, 1'b1, mk(0, 125, 0, 0, 0, 4));
    run_op("rndcy",   1'b0, 26'h3FFFFFF, 8'd127, 1'b1, 1'b0, mk(0, 128, 0, 0, 0, 5));
    run_op("ovf",     1'b1, 26'h0000000, 8'd254, 1'b0, 1'b0, mk(0, 255, 1, 0, 0, 3));
    run_op("zero",    1'b0, 26'h0000000, 8'd127, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 1));
    run_op("denorm",  1'b0, 26'h0000004, 8'd2,   1'b0, 1'b0, mk(2, 0, 0, 1, 0, 3));
    run_op("exp255",  1'b0, 26'h2000000, 8'd255, 1'b0, 1'b0, mk(0, 255, 1, 0, 0, 2));
    run_op("exp0",    1'b0, 26'h2000000, 8'd0,   1'b0, 1'b0, mk(0, 1, 0, 0, 0, 2));
    run_op("tie_odd", 1'b0, 26'h2000006, 8'd100, 1'b0, 1'b0, mk(2, 100, 0, 0, 0, 2));
    run_op("tie_evn", 1'b0, 26'h2000002, 8'd100, 1'b0, 1'b0, mk(0, 100, 0, 0, 0, 2));
    run_op("worst",   1'b0, 26'h0000001, 8'd200, 1'b0, 1'b0, mk(0, 175, 0, 0, 0, 27));

    for (int i = 0; i < 150; i++) begin
      rc  = ($urandom % 4) == 0;
      rm  = 26'($urandom) >> ($urandom % 27);
      sel = $urandom % 8;
      case (sel)
        0: re = 8'd0;
        1: re = 8'd1;
        2: re = 8'd254;
        3: re = 8'd255;
        default: re = 8'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), rc, rm, re, 1'($urandom), 1'($urandom), model(rc, rm, re));
    end

    @(negedge clk);
    mantissa_in = 26'h0000001;
    carry_in    = 1'b0;
    exponent_in = 8'd127;
    sign_in     = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst.abort", {busy, done, sign_out, overflow, underflow, zero, exponent_out, mantissa_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("rst.no_done", saw_done, 0);

    run_op("post_rst", 1'b0, 26'h2000000, 8'd127, 1'b0, 1'b0, mk(0, 127, 0, 0, 0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
